// File: rtl/wb_arbiter.sv
// Two-port register-file writeback arbiter: buffers ALU and load-unit writes
// and issues at most one register-file write per cycle, round-robin on contention.
module wb_arbiter #(
  parameter int BITS      = 32,
  parameter int WORDS     = 32,
  parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
  input  logic               clk,
  input  logic               rst_,

  input  logic               a_valid,
  output logic               a_ready,
  input  logic [ADDR_LEFT:0] a_waddr,
  input  logic [BITS-1:0]    a_wdata,
  input  logic [3:0]         a_byte_en,

  input  logic               b_valid,
  output logic               b_ready,
  input  logic [ADDR_LEFT:0] b_waddr,
  input  logic [BITS-1:0]    b_wdata,
  input  logic [3:0]         b_byte_en,

  output logic               rf_rw_,
  output logic [ADDR_LEFT:0] rf_waddr,
  output logic [BITS-1:0]    rf_wdata,
  output logic [3:0]         rf_byte_en,
  output logic [WORDS-1:0]   pend_mask
);

  localparam int AW = ADDR_LEFT + 1;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  logic               a_full_q, a_full_d;
  logic [ADDR_LEFT:0] a_addr_q, a_addr_d;
  logic [BITS-1:0]    a_data_q, a_data_d;
  logic [3:0]         a_be_q,   a_be_d;

  logic               b_full_q, b_full_d;
  logic [ADDR_LEFT:0] b_addr_q, b_addr_d;
  logic [BITS-1:0]    b_data_q, b_data_d;
  logic [3:0]         b_be_q,   b_be_d;

  logic               out_vld_q,  out_vld_d;
  logic [ADDR_LEFT:0] out_addr_q, out_addr_d;
  logic [BITS-1:0]    out_data_q, out_data_d;
  logic [3:0]         out_be_q,   out_be_d;

  port_e              rr_last_q, rr_last_d;

  logic               grant_a;
  logic               grant_b;
  logic               contend;
  logic               a_load;
  logic               b_load;

  function automatic logic [WORDS-1:0] one_hot(input logic [ADDR_LEFT:0] addr);
    logic [WORDS-1:0] v;
    v = '0;
    for (int i = 0; i < WORDS; i++) begin
      v[i] = (addr == AW'(i));
    end
    return v;
  endfunction

  // Equal addresses always favour B so the A value lands last in the file.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    rr_last_d = rr_last_q;
    contend   = a_full_q & b_full_q;
    if (contend) begin
      if ((a_addr_q == b_addr_q) || (rr_last_q == PORT_A)) begin
        grant_b   = 1'b1;
        rr_last_d = PORT_B;
      end else begin
        grant_a   = 1'b1;
        rr_last_d = PORT_A;
      end
    end else begin
      grant_a = a_full_q;
      grant_b = b_full_q;
    end
  end

  always_comb begin
    a_ready = rst_ & (~a_full_q | grant_a);
    b_ready = rst_ & (~b_full_q | grant_b);
    a_load  = a_valid & a_ready & (a_waddr != '0);
    b_load  = b_valid & b_ready & (b_waddr != '0);
  end

  always_comb begin
    a_full_d = a_full_q;
    a_addr_d = a_addr_q;
    a_data_d = a_data_q;
    a_be_d   = a_be_q;
    if (grant_a) begin
      a_full_d = 1'b0;
    end
    if (a_load) begin
      a_full_d = 1'b1;
      a_addr_d = a_waddr;
      a_data_d = a_wdata;
      a_be_d   = a_byte_en;
    end
  end

  always_comb begin
    b_full_d = b_full_q;
    b_addr_d = b_addr_q;
    b_data_d = b_data_q;
    b_be_d   = b_be_q;
    if (grant_b) begin
      b_full_d = 1'b0;
    end
    if (b_load) begin
      b_full_d = 1'b1;
      b_addr_d = b_waddr;
      b_data_d = b_wdata;
      b_be_d   = b_byte_en;
    end
  end

  always_comb begin
    out_vld_d  = grant_a | grant_b;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_be_d   = out_be_q;
    if (grant_a) begin
      out_addr_d = a_addr_q;
      out_data_d = a_data_q;
      out_be_d   = a_be_q;
    end else if (grant_b) begin
      out_addr_d = b_addr_q;
      out_data_d = b_data_q;
      out_be_d   = b_be_q;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      a_full_q   <= 1'b0;
      a_addr_q   <= '0;
      a_data_q   <= '0;
      a_be_q     <= '0;
      b_full_q   <= 1'b0;
      b_addr_q   <= '0;
      b_data_q   <= '0;
      b_be_q     <= '0;
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_be_q   <= '0;
      rr_last_q  <= PORT_B;
    end else begin
      a_full_q   <= a_full_d;
      a_addr_q   <= a_addr_d;
      a_data_q   <= a_data_d;
      a_be_q     <= a_be_d;
      b_full_q   <= b_full_d;
      b_addr_q   <= b_addr_d;
      b_data_q   <= b_data_d;
      b_be_q     <= b_be_d;
      out_vld_q  <= out_vld_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_be_q   <= out_be_d;
      rr_last_q  <= rr_last_d;
    end
  end

  always_comb begin
    rf_rw_     = ~out_vld_q;
    rf_waddr   = out_vld_q ? out_addr_q : '0;
    rf_wdata   = out_vld_q ? out_data_q : '0;
    rf_byte_en = out_vld_q ? out_be_q   : '0;
  end

  always_comb begin
    pend_mask = '0;
    if (a_full_q) begin
      pend_mask = pend_mask | one_hot(a_addr_q);
    end
    if (b_full_q) begin
      pend_mask = pend_mask | one_hot(b_addr_q);
    end
    if (out_vld_q) begin
      pend_mask = pend_mask | one_hot(out_addr_q);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// compared each cycle against a port-indexed behavioural model.
module tb_wb_arbiter;

  localparam int BITS  = 32;
  localparam int WORDS = 32;
  localparam int AW    = $clog2(WORDS);

  logic             clk = 1'b0;
  logic             rst_;
  logic             a_valid, b_valid;
  logic             a_ready, b_ready;
  logic [AW-1:0]    a_waddr, b_waddr, rf_waddr;
  logic [BITS-1:0]  a_wdata, b_wdata, rf_wdata;
  logic [3:0]       a_byte_en, b_byte_en, rf_byte_en;
  logic             rf_rw_;
  logic [WORDS-1:0] pend_mask;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: index 0 is port A, index 1 is port B.
  bit              m_full [2];
  int              m_addr [2];
  logic [BITS-1:0] m_data [2];
  logic [3:0]      m_be   [2];
  bit              m_ovld;
  int              m_oaddr;
  logic [BITS-1:0] m_odata;
  logic [3:0]      m_obe;
  int              m_last;
  bit              m_rst;
  int              m_loads    = 0;
  int              dut_writes = 0;

  bit   sat_on     = 1'b0;
  int   sat_writes = 0;
  int   sat_prev   = -1;

  wb_arbiter #(.BITS(BITS), .WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_waddr    (a_waddr),
    .a_wdata    (a_wdata),
    .a_byte_en  (a_byte_en),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_waddr    (b_waddr),
    .b_wdata    (b_wdata),
    .b_byte_en  (b_byte_en),
    .rf_rw_     (rf_rw_),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_byte_en (rf_byte_en),
    .pend_mask  (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic expectEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int modelGrant();
    if (m_full[0] && m_full[1]) return (m_addr[0] == m_addr[1]) ? 1 : 1 - m_last;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit modelReady(input int p);
    return !m_rst && (!m_full[p] || modelGrant() == p);
  endfunction

  task automatic modelReset();
    m_rst   = 1'b1;
    m_full  = '{1'b0, 1'b0};
    m_ovld  = 1'b0;
    m_last  = 1;
  endtask

  task automatic checkOutput(input string tag);
    logic [WORDS-1:0] pend;
    pend = '0;
    for (int p = 0; p < 2; p++) if (m_full[p]) pend[m_addr[p]] = 1'b1;
    if (m_ovld) pend[m_oaddr] = 1'b1;
    expectEq({tag, ".a_ready"},    a_ready,    modelReady(0));
    expectEq({tag, ".b_ready"},    b_ready,    modelReady(1));
    expectEq({tag, ".rf_rw_"},     rf_rw_,     !m_ovld);
    expectEq({tag, ".rf_waddr"},   rf_waddr,   m_ovld ? 64'(m_oaddr) : 64'd0);
    expectEq({tag, ".rf_wdata"},   rf_wdata,   m_ovld ? 64'(m_odata) : 64'd0);
    expectEq({tag, ".rf_byte_en"}, rf_byte_en, m_ovld ? 64'(m_obe)   : 64'd0);
    expectEq({tag, ".pend_mask"},  pend_mask,  pend);
    if (rf_rw_ === 1'b0) begin
      dut_writes++;
      if (sat_on) begin
        sat_writes++;
        if (sat_prev >= 0) expectEq("sat.alternate", rf_waddr[0], !sat_prev[0]);
        sat_prev = int'(rf_waddr[0]);
      end
    end
  endtask

  task automatic applyStimulus(input bit av, input int aa, input logic [BITS-1:0] ad,
                               input logic [3:0] ab, input bit bv, input int ba,
                               input logic [BITS-1:0] bd, input logic [3:0] bb);
    bit acc [2];
    int g;
    bit both;
    checkOutput("step");
    a_valid = av; a_waddr = AW'(aa); a_wdata = ad; a_byte_en = ab;
    b_valid = bv; b_waddr = AW'(ba); b_wdata = bd; b_byte_en = bb;
    acc[0] = av && modelReady(0);
    acc[1] = bv && modelReady(1);
    g      = modelGrant();
    both   = m_full[0] && m_full[1];
    @(posedge clk);
    m_ovld = (g >= 0);
    if (g >= 0) begin
      m_oaddr   = m_addr[g];
      m_odata   = m_data[g];
      m_obe     = m_be[g];
      m_full[g] = 1'b0;
      if (both) m_last = g;
    end
    if (acc[0] && aa != 0) begin
      m_full[0] = 1'b1; m_addr[0] = aa; m_data[0] = ad; m_be[0] = ab; m_loads++;
    end
    if (acc[1] && ba != 0) begin
      m_full[1] = 1'b1; m_addr[1] = ba; m_data[1] = bd; m_be[1] = bb; m_loads++;
    end
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, '0, '0, 1'b0, 0, '0, '0);
  endtask

  task automatic doReset();
    rst_ = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    modelReset();
    #2;
    checkOutput("reset");
    @(negedge clk);
    rst_  = 1'b1;
    m_rst = 1'b0;
    @(posedge clk);
    #1;
    expectEq("reset.a_ready_after", a_ready, 1'b1);
    expectEq("reset.b_ready_after", b_ready, 1'b1);
  endtask

  initial begin
    rst_ = 1'b0;
    a_valid = 1'b0; a_waddr = '0; a_wdata = '0; a_byte_en = '0;
    b_valid = 1'b0; b_waddr = '0; b_wdata = '0; b_byte_en = '0;
    modelReset();

    doReset();
    expectEq("reset.rf_rw_", rf_rw_, 1'b1);
    expectEq("reset.pend",   pend_mask, 0);

    // Single uncontended write.
    applyStimulus(1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b0, 0, '0, '0);
    expectEq("single.pend_k",   pend_mask[5], 1'b1);
    expectEq("single.rw_k",     rf_rw_, 1'b1);
    idle();
    expectEq("single.rw_k1",    rf_rw_, 1'b0);
    expectEq("single.addr_k1",  rf_waddr, 5);
    expectEq("single.data_k1",  rf_wdata, 32'hDEADBEEF);
    expectEq("single.pend_k1",  pend_mask[5], 1'b1);
    idle();
    expectEq("single.rw_k2",    rf_rw_, 1'b1);
    expectEq("single.pend_k2",  pend_mask, 0);

    // Contention right after reset: A wins first.
    doReset();
    applyStimulus(1'b1, 3, 32'h3333, 4'hF, 1'b1, 7, 32'h7777, 4'hF);
    expectEq("cont.a_ready", a_ready, 1'b1);
    expectEq("cont.b_ready", b_ready, 1'b0);
    idle();
    expectEq("cont.first",  rf_waddr, 3);
    idle();
    expectEq("cont.second", rf_waddr, 7);
    idle();

    // Same address: B first, A last; then A must win the next contention.
    applyStimulus(1'b1, 9, 32'h1, 4'hF, 1'b1, 9, 32'h2, 4'hF);
    idle();
    expectEq("same.first",  rf_wdata, 32'h2);
    idle();
    expectEq("same.second", rf_wdata, 32'h1);
    idle();
    applyStimulus(1'b1, 4, 32'h44, 4'h3, 1'b1, 6, 32'h66, 4'hC);
    idle();
    expectEq("rr.after_same", rf_waddr, 4);
    idle();
    expectEq("rr.then_b", rf_waddr, 6);
    idle();

    // Zero address is swallowed.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 0, 32'hFFFF, 4'hF, 1'b0, 0, '0, '0);
      expectEq("zero.rw",   rf_rw_, 1'b1);
      expectEq("zero.pend", pend_mask, 0);
    end
    idle();

    // Saturation: odd addresses on A, even on B.
    sat_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1 + 2 * (i % 15), $urandom, 4'($urandom),
                    1'b1, 2 + 2 * (i % 15), $urandom, 4'($urandom));
    end
    idle();
    idle();
    sat_on = 1'b0;
    expectEq("sat.writes", sat_writes, 20);
    for (int i = 0; i < 4; i++) idle();

    // Random traffic with small address range to provoke equal and zero addresses.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom, 4'($urandom),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom, 4'($urandom));
    end
    for (int i = 0; i < 4; i++) idle();
    expectEq("total.writes", dut_writes, m_loads);

    // Reset with both buffers full and the output stage loaded.
    applyStimulus(1'b1, 10, 32'hA0, 4'hF, 1'b1, 11, 32'hB0, 4'hF);
    applyStimulus(1'b1, 12, 32'hA1, 4'hF, 1'b1, 13, 32'hB1, 4'hF);
    a_valid = 1'b0; b_valid = 1'b0;
    expectEq("mid.pre_rw", rf_rw_, 1'b0);
    #2;
    rst_ = 1'b0;
    modelReset();
    #1;
    checkOutput("mid.async");
    expectEq("mid.rw",   rf_rw_, 1'b1);
    expectEq("mid.pend", pend_mask, 0);
    @(posedge clk);
    #1;
    checkOutput("mid.held");
    @(negedge clk);
    rst_  = 1'b1;
    m_rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      idle();
      expectEq("mid.no_write", rf_rw_, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter BITS, default 32, width in bits of a register-file data word.
REQ-002 Parameter WORDS, default 32, number of register-file entries.
REQ-003 Parameter ADDR_LEFT, default $clog2(WORDS)-1, MSB index of a register address.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_  input  1  system reset; asynchronous, active low.
REQ-007 a_valid  input  1  port A (ALU writeback) request valid.
REQ-008 a_ready  output  1  port A can accept a request this cycle.
REQ-009 a_waddr / a_wdata / a_byte_en  input  ADDR_LEFT+1 / BITS / 4  port A destination register, data and byte enables.
REQ-010 b_valid, b_ready, b_waddr, b_wdata, b_byte_en  same as port A  port B (load-unit writeback).
REQ-011 rf_rw_  output  1  register-file write strobe: 0 = write, 1 = read.
REQ-012 rf_waddr / rf_wdata / rf_byte_en  output  ADDR_LEFT+1 / BITS / 4  register-file write address, data and byte enables.
REQ-013 pend_mask  output  WORDS  bit i = 1 when a write to register i is buffered or in the output stage.

Function
REQ-014 The block SHALL keep one holding buffer per port (full flag, addr, data, byte_en) and one output register (out_vld, addr, data, byte_en).
REQ-015 A port request SHALL be accepted on a rising edge when valid=1 and ready=1 at that edge.
REQ-016 ready_x SHALL be rst_ AND (buffer_x empty OR buffer_x granted this cycle); a full buffer SHALL be drained and reloaded on the same edge.
REQ-017 An accepted request with waddr=0 SHALL be discarded: no buffer load, no grant, no write, no pend_mask change.
REQ-018 Each cycle the arbiter SHALL grant at most one full buffer; the granted entry moves to the output register and its buffer clears (unless reloaded) on the same edge.
REQ-019 With exactly one buffer full, that buffer SHALL be granted.
REQ-020 With both buffers full and different waddr, the grant SHALL go to the port other than rr_last, and rr_last SHALL be updated to the granted port.
REQ-021 With both buffers full and equal waddr, port B SHALL be granted first, so the port A value is written last; rr_last SHALL be set to B.
REQ-022 Single-contender grants (REQ-019) SHALL NOT change rr_last.
REQ-023 out_vld SHALL be 1 in the cycle after an edge that performed a grant, otherwise 0.
REQ-024 rf_rw_ SHALL equal NOT out_vld.
REQ-025 rf_waddr, rf_wdata and rf_byte_en SHALL come from the output register when out_vld=1 and SHALL be all-zero when out_vld=0.
REQ-026 Uncontended latency: a request accepted at edge k SHALL drive rf_rw_=0 from edge k+1 and commit in the register file at edge k+2.
REQ-027 Byte enables and data SHALL pass through unmodified; any byte masking or zero-fill is done by the register file.
REQ-028 pend_mask SHALL be the combinational OR of one-hot(addr) over each full buffer and over the output register when out_vld=1.
REQ-029 Sustained throughput SHALL be one register-file write per cycle; under continuous contention each port SHALL receive one grant every two cycles.

Reset
REQ-030 While rst_=0, independent of clk, the block SHALL: clear both buffers, set out_vld=0, set rr_last=B (port A wins the first contention), and drive rf_rw_=1, rf_waddr/rf_wdata/rf_byte_en=0, pend_mask=0 and a_ready=b_ready=0.
REQ-031 A reset asserted mid-operation SHALL discard all buffered and staged writes; no register-file write SHALL occur from them.
REQ-032 On the first edge after rst_ deasserts, a_ready and b_ready SHALL be 1.

Verification
REQ-033 Single write: A writes addr 5, data 0xDEADBEEF, byte_en 4'hF at edge k -> rf_rw_=0, rf_waddr=5, rf_wdata=0xDEADBEEF from edge k+1 for one cycle; pend_mask bit 5 set from edge k through edge k+2.
REQ-034 Contention: A writes addr 3 and B writes addr 7 at the same edge right after reset -> addr 3 written first, then addr 7 on the next cycle; a_ready=1 and b_ready=0 in the cycle after acceptance.
REQ-035 Same address: A (addr 9, 0x1) and B (addr 9, 0x2) accepted at the same edge -> write 0x2 then 0x1; rr_last=B.
REQ-036 Zero address: A writes addr 0 with a_valid held for 3 cycles -> rf_rw_ stays 1 and pend_mask stays 0.
REQ-037 Saturation: both ports valid every cycle for 20 cycles with distinct addresses -> 20 write cycles, grants alternate A/B, no request lost or duplicated.
REQ-038 Reset mid-flight: both buffers full and out_vld=1, then rst_ pulsed low -> rf_rw_=1 immediately, pend_mask=0, and no write of the buffered data follows.
